alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, pipelined integer execution unit for the out-of-order RISC-V core. It accepts one operation per cycle from the reservation station using a valid/ready handshake and computes RV32I ALU or branch-compare results. Results pass through a configurable number of register stages and are presented to the CDB arbiter with the originating ROB tag. It supports stall from the CDB, global pause via `rdy`, and flush on misprediction.

## Interface
Parameters:
- `XLEN`, 32: operand and result width.
- `ROB_W`, `` `ROB_SIZE_WIDTH ``: ROB tag width.
- `STAGES`, 2: pipeline depth, range 1..4; latency from accept to `out_valid`.

Ports:
- `clk`  in  1  the only clock; all logic is on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `rdy`  in  1  global enable; while low, all state holds.
- `clear`  in  1  misprediction flush.
- `in_valid`  in  1  operation offered.
- `in_ready`  out  1  unit can accept this cycle.
- `rob_id_in`  in  ROB_W  tag of the offered operation.
- `op`  in  5  operation code (encoding below).
- `v1`, `v2`  in  XLEN  operands.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  CDB grant.
- `rob_id_out`  out  ROB_W  tag of the result.
- `result`  out  XLEN  computed value.

## Operation
- Op encoding:
  - `op[4]=0`: ALU op selected by `op[2:0]` = funct3.
    - 000: add, or sub when `op[3]=1`.
    - 001: sll.
    - 010: slt.
    - 011: sltu.
    - 100: xor.
    - 101: srl, or sra when `op[3]=1`.
    - 110: or.
    - 111: and.
  - `op[4]=1`: branch compare giving 1/0, by `op[2:0]`.
    - 000: beq. 001: bne. 100: blt. 101: bge. 110: bltu. 111: bgeu.
    - 010 and 011 give `result = 0`.
- Shift amount is `v2[4:0]`. slt, blt and bge compare signed; all other compares are unsigned.
- Add and sub wrap modulo 2^XLEN.
- Accept occurs when `in_valid && in_ready`. The result is computed combinationally, captured in stage 0, and shifted toward stage `STAGES-1`. The last stage drives the outputs.
- Stall: `stall = out_valid && !out_ready`. While stalled, every stage holds and `in_ready = 0`.
- `in_ready = rdy && !stall && !clear`.
- Priority: `rst` > `!rdy` > `clear` > normal.
  - `rdy` low: no stage changes and `clear` is ignored.
  - `clear` with `rdy` high: every stage valid bit goes to 0 on that edge. Any offered input is dropped. Data registers need not be zeroed.
- `out_valid` with `out_ready` high in the same cycle: the result retires and the pipeline advances, so a new result may be valid on the next edge (full throughput).
- `result` and `rob_id_out` are stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid = 0`, `result = 0`, `rob_id_out = 0`, all stage valids 0.
- `in_ready` is combinational and is 1 after reset when `rdy = 1`.
- Latency: an op accepted at edge N gives `out_valid` high after edge N+STAGES-1, i.e. during cycle N+STAGES with no stalls. With `STAGES=1` the result is visible the cycle after accept.
- Throughput: 1 op/cycle when `out_ready` is held high.
- A stall of k cycles delays every in-flight op by k cycles. No op is lost or duplicated.
- `rst` asserted mid-stream: all in-flight ops are discarded on that edge.

## Configuration
- Macro: `ALU_PIPE_MUL_EN`.
- Defined: `op = 5'b11xxx` selects M-extension multiply by `op[2:0]`:
  - 000: mul, low XLEN bits.
  - 001: mulh, signed×signed, high bits.
  - 010: mulhsu, signed×unsigned, high bits.
  - 011: mulhu, unsigned×unsigned, high bits.
  - 100–111: `result = 0`.
- Multiply uses the same latency as every other op. When `STAGES >= 2`, the product is split across stages 0 and 1 (partial products, then sum).
- Undefined: `op[3]` is ignored when `op[4]=1`, so 11xxx decodes as a branch compare. No multiplier logic is synthesised.

## Structure
- The op-code field positions and funct3 constants, plus the `ALU_PIPE_MUL_EN` default (off), go in shared `config.v` alongside `` `ROB_SIZE_WIDTH ``.
- Sub-module `alu_core`: purely combinational `op`, `v1`, `v2` → `result`. It is reused by the branch unit.
- `alu_pipe` owns the stage registers, valid bits, stall logic and flush.

## Test plan
- Reset, then with STAGES=2 and `out_ready=1`, send add `v1=5`, `v2=7`, tag 3 → `result=12`, `rob_id_out=3`, `out_valid` high exactly 2 cycles after accept.
- Back-to-back:
  - sub `1-2` → `0xFFFFFFFF`.
  - sra `0x80000000>>>4` → `0xF8000000`.
  - bltu `1 < 0xFFFFFFFF` → 1.
  - blt `1 < 0xFFFFFFFF` (signed) → 0.
  - Four results come out on four consecutive cycles, in order.
- Hold `out_ready=0` for 3 cycles with the pipe full → `in_ready=0`, outputs stable. On release, each op retires once in order, with no loss.
- Assert `clear` with 2 ops in flight plus one offered → no `out_valid` for those ops. An op accepted the next cycle completes normally.
- Drop `rdy` for 2 cycles mid-stream with `clear` also high → state frozen and `clear` ignored. Resumes with the same results.
- With `ALU_PIPE_MUL_EN`:
  - mulh `0xFFFFFFFF × 0xFFFFFFFF` → 0.
  - mulhu of the same operands → `0xFFFFFFFE`.
  - mul `3 × -4` → `0xFFFFFFF4`.
- Without `ALU_PIPE_MUL_EN`: `op=5'b11000`, `v1=v2` → 1 (beq).

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// alu_pipe_pkg: op-code field layout and funct3 constants for alu_pipe.
// Define ALU_PIPE_MUL_EN to enable the M-extension multiply (off by default).
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package alu_pipe_pkg;

    localparam int OP_W   = 5;
    localparam int OP_BR  = 4;
    localparam int OP_ALT = 3;

`ifdef ALU_PIPE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_SLL  = 3'b001,
        F3_SLT  = 3'b010,
        F3_SLTU = 3'b011,
        F3_XOR  = 3'b100,
        F3_SR   = 3'b101,
        F3_OR   = 3'b110,
        F3_AND  = 3'b111
    } alu_f3_e;

    typedef enum logic [2:0] {
        BR_EQ  = 3'b000,
        BR_NE  = 3'b001,
        BR_LT  = 3'b100,
        BR_GE  = 3'b101,
        BR_LTU = 3'b110,
        BR_GEU = 3'b111
    } br_f3_e;

    typedef enum logic [2:0] {
        M_MUL    = 3'b000,
        M_MULH   = 3'b001,
        M_MULHSU = 3'b010,
        M_MULHU  = 3'b011
    } mul_f3_e;

    typedef enum logic [1:0] {
        K_ALU,
        K_BR,
        K_MUL
    } op_kind_e;

    // Without the multiplier, op[3] is a don't-care for branches.
    function automatic op_kind_e op_kind(
        input logic br,
        input logic alt
    );
        if (br && alt && MUL_EN)
            return K_MUL;
        return br ? K_BR : K_ALU;
    endfunction

endpackage

// File: rtl/alu_core.sv
// alu_core: combinational RV32I ALU / branch compare (optional multiply).
// Multiply is present only when ALU_PIPE_MUL_EN is defined.
module alu_core
    import alu_pipe_pkg::*;
#(
    parameter int XLEN = 32
`ifdef ALU_PIPE_MUL_EN
    , parameter bit FULL_MUL = 1'b1
`endif
) (
    input  logic [OP_W-1:0] op,
    input  logic [XLEN-1:0] v1,
    input  logic [XLEN-1:0] v2,
    output logic [XLEN-1:0] result
);

    op_kind_e        kind;
    logic [4:0]      sh;
    logic [XLEN-1:0] sra;
    logic            lt;
    logic            ltu;
    logic            eq;

    assign kind = op_kind(op[OP_BR], op[OP_ALT]);
    assign sh   = v2[4:0];
    assign sra  = $signed(v1) >>> sh;
    assign lt   = $signed(v1) < $signed(v2);
    assign ltu  = v1 < v2;
    assign eq   = v1 == v2;

`ifdef ALU_PIPE_MUL_EN
    logic signed [XLEN:0]     ma;
    logic signed [XLEN:0]     mb;
    logic signed [2*XLEN+1:0] prod;

    // mulhu is the only op with an unsigned v1.
    assign ma   = {(op[2:0] != M_MULHU) && v1[XLEN-1], v1};
    assign mb   = {(op[2:0] == M_MULH) && v2[XLEN-1], v2};
    assign prod = ma * mb;
`endif

    always_comb begin
        result = '0;
        unique case (1'b1)
            kind == K_ALU: begin
                case (op[2:0])
                    F3_ADD:  result = op[OP_ALT] ? v1 - v2 : v1 + v2;
                    F3_SLL:  result = v1 << sh;
                    F3_SLT:  result = XLEN'(lt);
                    F3_SLTU: result = XLEN'(ltu);
                    F3_XOR:  result = v1 ^ v2;
                    F3_SR:   result = op[OP_ALT] ? sra : v1 >> sh;
                    F3_OR:   result = v1 | v2;
                    F3_AND:  result = v1 & v2;
                    default: result = '0;
                endcase
            end
            kind == K_BR: begin
                case (op[2:0])
                    BR_EQ:   result = XLEN'(eq);
                    BR_NE:   result = XLEN'(!eq);
                    BR_LT:   result = XLEN'(lt);
                    BR_GE:   result = XLEN'(!lt);
                    BR_LTU:  result = XLEN'(ltu);
                    BR_GEU:  result = XLEN'(!ltu);
                    default: result = '0;
                endcase
            end
            kind == K_MUL: begin
`ifdef ALU_PIPE_MUL_EN
                if (FULL_MUL) begin
                    case (op[2:0])
                        M_MUL:    result = prod[XLEN-1:0];
                        M_MULH,
                        M_MULHSU,
                        M_MULHU:  result = prod[2*XLEN-1:XLEN];
                        default:  result = '0;
                    endcase
                end
`else
                result = '0;
`endif
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: pipelined ALU/branch unit with valid/ready, stall and flush.
// Define ALU_PIPE_MUL_EN to add multiply; STAGES sets the latency.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ROB_W  = `ROB_SIZE_WIDTH,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [ROB_W-1:0] rob_id_in,
    input  logic [OP_W-1:0]  op,
    input  logic [XLEN-1:0]  v1,
    input  logic [XLEN-1:0]  v2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROB_W-1:0] rob_id_out,
    output logic [XLEN-1:0]  result
);

`ifdef ALU_PIPE_MUL_EN
    localparam bit SPLIT = STAGES > 1;
`endif

    logic [STAGES-1:0] vld;
    logic [XLEN-1:0]   dat [STAGES];
    logic [ROB_W-1:0]  tag [STAGES];
    logic [XLEN-1:0]   core_res;
    logic [XLEN-1:0]   s1_d;
    logic              stall;
    logic              adv;

    assign stall      = vld[STAGES-1] && !out_ready;
    assign adv        = rdy && !stall;
    assign in_ready   = rdy && !stall && !clear;
    assign out_valid  = vld[STAGES-1];
    assign result     = dat[STAGES-1];
    assign rob_id_out = tag[STAGES-1];

    alu_core #(
        .XLEN(XLEN)
`ifdef ALU_PIPE_MUL_EN
        , .FULL_MUL(!SPLIT)
`endif
    ) u_core (
        .op    (op),
        .v1    (v1),
        .v2    (v2),
        .result(core_res)
    );

    // Flush beats stall: a held result is dropped too.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (rdy) begin
            if (clear)
                vld <= '0;
            else if (!stall)
                vld <= STAGES'({vld, in_valid});
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                dat[i] <= '0;
                tag[i] <= '0;
            end
        end else if (adv) begin
            dat[0] <= core_res;
            tag[0] <= rob_id_in;
            for (int i = 1; i < STAGES; i++) begin
                dat[i] <= (i == 1) ? s1_d : dat[i-1];
                tag[i] <= tag[i-1];
            end
        end
    end

`ifdef ALU_PIPE_MUL_EN
    if (SPLIT) begin : g_mul
        localparam int H  = XLEN / 2;
        localparam int PW = 2 * XLEN + 2;

        logic signed [XLEN:0] ma;
        logic signed [XLEN:0] mb;
        logic signed [PW-1:0] pl_d;
        logic signed [PW-1:0] ph_d;
        logic signed [PW-1:0] pl_q;
        logic signed [PW-1:0] ph_q;
        logic [2*XLEN-1:0]    sum;
        logic                 mis_q;
        logic                 mhi_q;

        assign ma = {(op[2:0] != M_MULHU) && v1[XLEN-1], v1};
        assign mb = {(op[2:0] == M_MULH) && v2[XLEN-1], v2};

        // v2 split into signed high half and unsigned low half.
        assign pl_d = ma * $signed({1'b0, mb[H-1:0]});
        assign ph_d = ma * $signed(mb[XLEN:H]);
        assign sum  = (2*XLEN)'(pl_q + (ph_q <<< H));

        always_ff @(posedge clk) begin
            if (rst) begin
                pl_q  <= '0;
                ph_q  <= '0;
                mis_q <= 1'b0;
                mhi_q <= 1'b0;
            end else if (adv) begin
                pl_q  <= pl_d;
                ph_q  <= ph_d;
                mis_q <= (op_kind(op[OP_BR], op[OP_ALT]) == K_MUL)
                         && !op[2];
                mhi_q <= op[2:0] != M_MUL;
            end
        end

        assign s1_d = !mis_q ? dat[0]
                    : mhi_q  ? sum[2*XLEN-1:XLEN]
                    :          sum[XLEN-1:0];
    end else begin : g_nomul
        assign s1_d = dat[0];
    end
`else
    assign s1_d = dat[0];
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: randomized self-checking bench for alu_pipe.
// A behavioural model feeds a scoreboard checked on every retire.
`timescale 1ns/1ps
module tb_alu_pipe;

    localparam int XLEN   = 32;
    localparam int ROB_W  = 4;
    localparam int STAGES = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             clear;
    logic             in_valid;
    logic             in_ready;
    logic [ROB_W-1:0] rob_id_in;
    logic [4:0]       op;
    logic [XLEN-1:0]  v1;
    logic [XLEN-1:0]  v2;
    logic             out_valid;
    logic             out_ready;
    logic [ROB_W-1:0] rob_id_out;
    logic [XLEN-1:0]  result;

    int n_chk   = 0;
    int n_fail  = 0;
    int retired = 0;

    typedef struct packed {
        logic [ROB_W-1:0] tag;
        logic [XLEN-1:0]  val;
    } exp_t;

    exp_t expq[$];
    exp_t e;

    always #5 clk = ~clk;

    alu_pipe #(
        .XLEN  (XLEN),
        .ROB_W (ROB_W),
        .STAGES(STAGES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rob_id_in (rob_id_in),
        .op        (op),
        .v1        (v1),
        .v2        (v2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rob_id_out(rob_id_out),
        .result    (result)
    );

    function automatic logic [31:0] model(
        input logic [4:0]  o,
        input logic [31:0] a,
        input logic [31:0] b
    );
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        longint             p;
        longint unsigned    up;
        int unsigned        sh;
        sa = a;
        sb = b;
        sh = b[4:0];
        if (!o[4]) begin
            case (o[2:0])
                3'd0: return o[3] ? a - b : a + b;
                3'd1: return a << sh;
                3'd2: return {31'd0, sa < sb};
                3'd3: return {31'd0, a < b};
                3'd4: return a ^ b;
                3'd5: begin
                    if (o[3])
                        return sa >>> sh;
                    return a >> sh;
                end
                3'd6: return a | b;
                default: return a & b;
            endcase
        end
`ifdef ALU_PIPE_MUL_EN
        if (o[3]) begin
            case (o[2:0])
                3'd0: return a * b;
                3'd1: begin
                    p = longint'(sa) * longint'(sb);
                    return p[63:32];
                end
                3'd2: begin
                    p = longint'(sa) * longint'({32'd0, b});
                    return p[63:32];
                end
                3'd3: begin
                    up = {32'd0, a} * {32'd0, b};
                    return up[63:32];
                end
                default: return 32'd0;
            endcase
        end
`endif
        case (o[2:0])
            3'd0: return {31'd0, a == b};
            3'd1: return {31'd0, a != b};
            3'd4: return {31'd0, sa < sb};
            3'd5: return {31'd0, sa >= sb};
            3'd6: return {31'd0, a < b};
            3'd7: return {31'd0, a >= b};
            default: return 32'd0;
        endcase
    endfunction

    // Scoreboard: inputs only change at posedge+1, so the negedge
    // view is what the next rising edge acts on.
    always @(negedge clk) begin
        if (rst) begin
            expq.delete();
        end else if (rdy) begin
            if (out_valid && out_ready && !clear) begin
                n_chk++;
                if (expq.size() == 0) begin
                    n_fail++;
                    $display("FAIL retire_extra: tag %0d res %h, required none",
                             rob_id_out, result);
                end else begin
                    e = expq.pop_front();
                    retired++;
                    if (result !== e.val || rob_id_out !== e.tag) begin
                        n_fail++;
                        $display("FAIL retire: tag %0d res %h, required tag %0d res %h",
                                 rob_id_out, result, e.tag, e.val);
                    end
                end
            end
            if (clear)
                expq.delete();
            else if (in_valid && in_ready) begin
                e.tag = rob_id_in;
                e.val = model(op, v1, v2);
                expq.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(
        input logic [4:0]       o,
        input logic [31:0]      a,
        input logic [31:0]      b,
        input logic [ROB_W-1:0] t
    );
        in_valid  = 1'b1;
        op        = o;
        v1        = a;
        v2        = b;
        rob_id_in = t;
    endtask

    task automatic send_rand();
        send(5'($urandom), $urandom, $urandom, ROB_W'($urandom));
    endtask

    task automatic drain();
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (expq.size() == 0 && !out_valid)
                break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        out_ready = 1'b1; in_valid = 1'b0;
        op = '0; v1 = '0; v2 = '0; rob_id_in = '0;
        tick();
        tick();
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0 || result !== '0 || rob_id_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: ov %b res %h tag %0d, required 0 0 0",
                     out_valid, result, rob_id_out);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: in_ready %b ov %b, required 1 0",
                     in_ready, out_valid);
        end
        tick();
    endtask

    task automatic test_basic();
        send(5'b00000, 32'd5, 32'd7, 4'd3);
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_ready: %b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < STAGES - 1; i++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL basic_early: ov %b at %0d, required 0",
                         out_valid, i);
            end
            tick();
        end
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b1 || result !== 32'd12 || rob_id_out !== 4'd3) begin
            n_fail++;
            $display("FAIL basic_latency: ov %b res %h tag %0d, required 1 c 3",
                     out_valid, result, rob_id_out);
        end
        tick();
        @(negedge clk);
        n_chk++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_once: ov %b, required 0", out_valid);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  ops [4];
        logic [31:0] aa  [4];
        logic [31:0] bb  [4];
        logic [31:0] ex  [4];
        logic [31:0] got [4];
        logic [3:0]  gtag[4];
        int cnt = 0;
        int last = -1;
        bit consec = 1'b1;
        ops = '{5'b01000, 5'b01101, 5'b10110, 5'b10100};
        aa  = '{32'd1, 32'h8000_0000, 32'd1, 32'd1};
        bb  = '{32'd2, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        ex  = '{32'hFFFF_FFFF, 32'hF800_0000, 32'd1, 32'd0};
        out_ready = 1'b1;
        for (int c = 0; c < 4 + STAGES + 3; c++) begin
            if (c < 4)
                send(ops[c], aa[c], bb[c], 4'(c + 4));
            else
                in_valid = 1'b0;
            @(negedge clk);
            if (out_valid) begin
                if (cnt < 4) begin
                    got[cnt]  = result;
                    gtag[cnt] = rob_id_out;
                end
                if (cnt > 0 && c != last + 1)
                    consec = 1'b0;
                last = c;
                cnt++;
            end
            tick();
        end
        n_chk++;
        if (cnt != 4 || !consec) begin
            n_fail++;
            $display("FAIL b2b_timing: %0d results consec %b, required 4 1",
                     cnt, consec);
        end
        for (int i = 0; i < 4 && i < cnt; i++) begin
            n_chk++;
            if (got[i] !== ex[i] || gtag[i] !== 4'(i + 4)) begin
                n_fail++;
                $display("FAIL b2b_%0d: res %h tag %0d, required %h %0d",
                         i, got[i], gtag[i], ex[i], i + 4);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] r0;
        logic [3:0]  t0;
        int acc = 0;
        int r_before;
        r_before = retired;
        out_ready = 1'b0;
        for (int c = 0; c < STAGES + 2; c++) begin
            send_rand();
            @(negedge clk);
            if (in_valid && in_ready)
                acc++;
            tick();
        end
        send_rand();
        @(negedge clk);
        r0 = result;
        t0 = rob_id_out;
        n_chk++;
        if (out_valid !== 1'b1 || acc != STAGES) begin
            n_fail++;
            $display("FAIL stall_fill: ov %b accepted %0d, required 1 %0d",
                     out_valid, acc, STAGES);
        end
        for (int c = 0; c < 3; c++) begin
            tick();
            send_rand();
            @(negedge clk);
            n_chk++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1
                || result !== r0 || rob_id_out !== t0) begin
                n_fail++;
                $display("FAIL stall_hold: rdy %b ov %b res %h tag %0d, required 0 1 %h %0d",
                         in_ready, out_valid, result, rob_id_out, r0, t0);
            end
        end
        tick();
        drain();
        n_chk++;
        if (expq.size() != 0 || retired - r_before != acc) begin
            n_fail++;
            $display("FAIL stall_release: left %0d retired %0d, required 0 %0d",
                     expq.size(), retired - r_before, acc);
        end
    endtask

    task automatic test_clear();
        bit seen = 1'b0;
        out_ready = 1'b1;
        send(5'b00000, 32'd10, 32'd20, 4'd1);
        tick();
        send(5'b00110, 32'h00F0, 32'h0F00, 4'd2);
        tick();
        out_ready = 1'b0;
        clear = 1'b1;
        send(5'b00111, 32'hFFFF, 32'h00FF, 4'd3);
        @(negedge clk);
        n_chk++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_ready: %b, required 0", in_ready);
        end
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < STAGES + 1; c++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL clear_flush: ov %b tag %0d, required 0",
                         out_valid, rob_id_out);
            end
            tick();
        end
        send(5'b00100, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'd9);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < STAGES + 3 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n_chk++;
                if (result !== 32'hFF00_FF00 || rob_id_out !== 4'd9) begin
                    n_fail++;
                    $display("FAIL clear_after: res %h tag %0d, required ff00ff00 9",
                             result, rob_id_out);
                end
            end
            tick();
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL clear_after: no result, required one");
        end
    endtask

    task automatic test_rdy();
        logic [31:0] r0;
        logic [3:0]  t0;
        logic        ov0;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (c == 3 || c == 4) begin
                rdy = 1'b0;
                clear = 1'b1;
            end else begin
                rdy = 1'b1;
                clear = 1'b0;
            end
            if (c < 8)
                send_rand();
            else
                in_valid = 1'b0;
            @(negedge clk);
            if (c == 3) begin
                r0 = result;
                t0 = rob_id_out;
                ov0 = out_valid;
            end
            if (c == 3 || c == 4) begin
                n_chk++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rdy_ready: %b, required 0", in_ready);
                end
            end
            if (c == 4 || c == 5) begin
                n_chk++;
                if (out_valid !== ov0 || result !== r0 || rob_id_out !== t0) begin
                    n_fail++;
                    $display("FAIL rdy_frozen: ov %b res %h tag %0d, required %b %h %0d",
                             out_valid, result, rob_id_out, ov0, r0, t0);
                end
            end
            tick();
        end
        rdy = 1'b1;
        clear = 1'b0;
        drain();
        n_chk++;
        if (expq.size() != 0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_resume: left %0d ov %b, required 0 0",
                     expq.size(), out_valid);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 29) == 0);
            out_ready = !clear && ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 9) < 7)
                send_rand();
            else
                in_valid = 1'b0;
            tick();
        end
        rdy = 1'b1;
        clear = 1'b0;
        drain();
        n_chk++;
        if (expq.size() != 0) begin
            n_fail++;
            $display("FAIL random_drain: left %0d, required 0", expq.size());
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            send_rand();
            tick();
        end
        rst = 1'b1;
        send_rand();
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        for (int c = 0; c < STAGES + 2; c++) begin
            @(negedge clk);
            n_chk++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid: ov %b tag %0d, required 0",
                         out_valid, rob_id_out);
            end
            tick();
        end
    endtask

    task automatic test_single(
        input string       nm,
        input logic [4:0]  o,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] ex
    );
        bit seen = 1'b0;
        out_ready = 1'b1;
        send(o, a, b, 4'd11);
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < STAGES + 3 && !seen; c++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                n_chk++;
                if (result !== ex) begin
                    n_fail++;
                    $display("FAIL %s: res %h, required %h", nm, result, ex);
                end
            end
            tick();
        end
        if (!seen) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s: no result, required %h", nm, ex);
        end
    endtask

    task automatic test_opcfg();
`ifdef ALU_PIPE_MUL_EN
        test_single("mulh", 5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0);
        test_single("mulhu", 5'b11011, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                    32'hFFFF_FFFE);
        test_single("mul", 5'b11000, 32'd3, 32'hFFFF_FFFC, 32'hFFFF_FFF4);
        test_single("mulhsu", 5'b11010, 32'hFFFF_FFFF, 32'h0000_0002,
                    32'hFFFF_FFFF);
`else
        test_single("beq_alt", 5'b11000, 32'h1234, 32'h1234, 32'd1);
        test_single("bne_alt", 5'b11001, 32'h1234, 32'h1234, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, required finish");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_stall();
        test_clear();
        test_rdy();
        test_opcfg();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
